// File: rtl/daq_rx_pkg.sv
// Shared types and constants for the DAQ serial frame receiver.
// A frame is {channel, data, parity}, sent MSB first with even parity over the upper bits.
package daq_rx_pkg;

  localparam int CH_BITS       = 3;
  localparam int ADC_WIDTH     = 12;
  localparam int FRAME_BITS    = CH_BITS + ADC_WIDTH + 1;
  localparam int BIT_CNT_WIDTH = 5;

  // One buffered sample: the channel tag above the conversion result.
  typedef struct packed {
    logic [CH_BITS-1:0]   channel;
    logic [ADC_WIDTH-1:0] data;
  } daq_sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } rx_state_e;

  // True when the whole frame, parity bit included, has odd weight.
  function automatic logic frame_parity_bad(input logic [FRAME_BITS-1:0] frame);
    return ^frame;
  endfunction

endpackage

// File: rtl/daq_rx_fifo.sv
// Synchronous first-word-fall-through FIFO of daq_sample_t.
// The head entry is visible on o_data whenever o_empty is low; o_data reads 0 while empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module daq_rx_fifo
  import daq_rx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  daq_sample_t            i_data,
  input  logic                   i_pop,
  output daq_sample_t            o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  daq_sample_t   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_level == LVL_FULL);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage write at the tail.
  // NOTE: the memory array is left out of reset on purpose; o_data is masked while empty, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy tracking; power-of-two depth lets the pointers wrap naturally.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/daq_serial_frame_receiver.sv
// Receive-side deserializer for the DAQ controller's serial sample stream.
// Synchronizes serial_clk/serial_data/serial_valid, reassembles each frame,
// validates it, and buffers good samples in a FWFT FIFO behind a valid/ready port.
// Optional build macro DAQ_RX_PARITY_CHECK_EN: when defined, frames with bad
// parity are dropped and counted; otherwise the parity bit is ignored and
// parity_err_count is tied to 0.
// ADC_WIDTH and CH_BITS must match the daq_rx_pkg constants that size daq_sample_t.
module daq_serial_frame_receiver #(
  parameter int ADC_WIDTH  = 12,
  parameter int CH_BITS    = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          serial_clk,
  input  logic                          serial_data,
  input  logic                          serial_valid,
  input  logic                          clear_counts,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [CH_BITS-1:0]            m_channel,
  output logic [ADC_WIDTH-1:0]          m_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_WIDTH-1:0]          frame_count,
  output logic [CNT_WIDTH-1:0]          frame_err_count,
  output logic [CNT_WIDTH-1:0]          parity_err_count,
  output logic [CNT_WIDTH-1:0]          overflow_count
);

  import daq_rx_pkg::*;

  localparam int W_FRAME = CH_BITS + ADC_WIDTH + 1;
  localparam logic [BIT_CNT_WIDTH-1:0] BIT_ONE   = BIT_CNT_WIDTH'(1);
  localparam logic [BIT_CNT_WIDTH-1:0] BIT_MAX   = '1;
  localparam logic [BIT_CNT_WIDTH-1:0] FRAME_CNT = BIT_CNT_WIDTH'(W_FRAME);
  localparam logic [CNT_WIDTH-1:0]     CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]     CNT_MAX   = '1;

  // Synchronizer chains and the previous synchronized value for edge detection.
  logic [1:0] r_sclk_sync;
  logic [1:0] r_sdat_sync;
  logic [1:0] r_sval_sync;
  logic       r_sclk_q;
  logic       r_sval_q;
  logic       w_sclk_rise;
  logic       w_sval_rise;
  logic       w_sval_fall;

  // Frame assembly state.
  rx_state_e                r_state;
  logic [BIT_CNT_WIDTH-1:0] r_bit_cnt;
  logic [W_FRAME-1:0]       r_shift;
  logic                     r_push;
  logic                     r_inc_frame;
  logic                     r_inc_frame_err;
  logic                     r_inc_overflow;

  // Counters.
  logic [CNT_WIDTH-1:0] r_frame_count;
  logic [CNT_WIDTH-1:0] r_frame_err_count;
  logic [CNT_WIDTH-1:0] r_overflow_count;

  // FIFO interface.
  daq_sample_t                 w_frame_sample;
  daq_sample_t                 w_fifo_head;
  logic                        w_fifo_full;
  logic                        w_fifo_empty;
  logic                        w_pop;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_level;

  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_q;
  assign w_sval_rise = r_sval_sync[1] & ~r_sval_q;
  assign w_sval_fall = ~r_sval_sync[1] & r_sval_q;

  // The shift register holds the completed frame unchanged until the next frame starts,
  // so the push one cycle after CHECK can take its sample straight from it.
  assign w_frame_sample.channel = r_shift[W_FRAME-1 -: CH_BITS];
  assign w_frame_sample.data    = r_shift[ADC_WIDTH:1];

  assign w_pop      = !w_fifo_empty && m_ready;
  assign m_valid    = !w_fifo_empty;
  assign m_channel  = w_fifo_head.channel;
  assign m_data     = w_fifo_head.data;
  assign fifo_level = w_fifo_level;

  assign frame_count     = r_frame_count;
  assign frame_err_count = r_frame_err_count;
  assign overflow_count  = r_overflow_count;

  // Two-flop synchronizers plus one delay stage to detect edges on the synchronized copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_sdat_sync <= '0;
      r_sval_sync <= '0;
      r_sclk_q    <= 1'b0;
      r_sval_q    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], serial_clk};
      r_sdat_sync <= {r_sdat_sync[0], serial_data};
      r_sval_sync <= {r_sval_sync[0], serial_valid};
      r_sclk_q    <= r_sclk_sync[1];
      r_sval_q    <= r_sval_sync[1];
    end
  end

`ifdef DAQ_RX_PARITY_CHECK_EN
  logic                 r_inc_parity_err;
  logic [CNT_WIDTH-1:0] r_parity_err_count;
  logic                 w_parity_bad;

  assign w_parity_bad     = frame_parity_bad(r_shift);
  assign parity_err_count = r_parity_err_count;
`else
  logic w_unused_parity_bit;

  // The parity bit is still shifted in but plays no part in the decision.
  assign w_unused_parity_bit = r_shift[0];
  assign parity_err_count    = '0;
`endif

  // Frame FSM: envelope rise starts a frame, serial_clk rises shift bits in,
  // envelope fall triggers a one-cycle CHECK that registers the frame's fate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_bit_cnt       <= '0;
      r_shift         <= '0;
      r_push          <= 1'b0;
      r_inc_frame     <= 1'b0;
      r_inc_frame_err <= 1'b0;
      r_inc_overflow  <= 1'b0;
`ifdef DAQ_RX_PARITY_CHECK_EN
      r_inc_parity_err <= 1'b0;
`endif
    end else begin
      r_push          <= 1'b0;
      r_inc_frame     <= 1'b0;
      r_inc_frame_err <= 1'b0;
      r_inc_overflow  <= 1'b0;
`ifdef DAQ_RX_PARITY_CHECK_EN
      r_inc_parity_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_sval_rise) begin
            r_state   <= SHIFT;
            r_bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (w_sclk_rise) begin
            r_shift <= {r_shift[W_FRAME-2:0], r_sdat_sync[1]};
            if (r_bit_cnt != BIT_MAX) begin
              r_bit_cnt <= r_bit_cnt + BIT_ONE;
            end
          end
          if (w_sval_fall) begin
            r_state <= CHECK;
          end
        end
        CHECK: begin
          r_state <= IDLE;
          if (r_bit_cnt != FRAME_CNT) begin
            r_inc_frame_err <= 1'b1;
`ifdef DAQ_RX_PARITY_CHECK_EN
          end else if (w_parity_bad) begin
            r_inc_parity_err <= 1'b1;
`endif
          end else if (w_fifo_full && !w_pop) begin
            r_inc_overflow <= 1'b1;
          end else begin
            r_push      <= 1'b1;
            r_inc_frame <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Statistics counters: a clear pulse beats any increment, otherwise saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_count     <= '0;
      r_frame_err_count <= '0;
      r_overflow_count  <= '0;
    end else if (clear_counts) begin
      r_frame_count     <= '0;
      r_frame_err_count <= '0;
      r_overflow_count  <= '0;
    end else begin
      if (r_inc_frame && (r_frame_count != CNT_MAX)) begin
        r_frame_count <= r_frame_count + CNT_ONE;
      end
      if (r_inc_frame_err && (r_frame_err_count != CNT_MAX)) begin
        r_frame_err_count <= r_frame_err_count + CNT_ONE;
      end
      if (r_inc_overflow && (r_overflow_count != CNT_MAX)) begin
        r_overflow_count <= r_overflow_count + CNT_ONE;
      end
    end
  end

`ifdef DAQ_RX_PARITY_CHECK_EN
  // Parity error counter, same clear and saturation rules as the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err_count <= '0;
    end else if (clear_counts) begin
      r_parity_err_count <= '0;
    end else if (r_inc_parity_err && (r_parity_err_count != CNT_MAX)) begin
      r_parity_err_count <= r_parity_err_count + CNT_ONE;
    end
  end
`endif

  daq_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_push),
    .i_data  (w_frame_sample),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_fifo_level)
  );

endmodule

// File: tb/tb_daq_serial_frame_receiver.sv
// Self-checking bench for daq_serial_frame_receiver.
// Frames are driven at the serial level; expectations come from a queue-based
// model that applies the frame acceptance rules directly.
module tb_daq_serial_frame_receiver;

  localparam int ADC_WIDTH  = 12;
  localparam int CH_BITS    = 3;
  localparam int FIFO_DEPTH = 16;
  localparam int CNT_WIDTH  = 16;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

`ifdef DAQ_RX_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic                 clk          = 1'b0;
  logic                 rst_n        = 1'b0;
  logic                 serial_clk   = 1'b0;
  logic                 serial_data  = 1'b0;
  logic                 serial_valid = 1'b0;
  logic                 clear_counts = 1'b0;
  logic                 m_ready      = 1'b0;
  logic                 m_valid;
  logic [CH_BITS-1:0]   m_channel;
  logic [ADC_WIDTH-1:0] m_data;
  logic [LVL_W-1:0]     fifo_level;
  logic [CNT_WIDTH-1:0] frame_count;
  logic [CNT_WIDTH-1:0] frame_err_count;
  logic [CNT_WIDTH-1:0] parity_err_count;
  logic [CNT_WIDTH-1:0] overflow_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: expected FIFO contents and counter values.
  logic [14:0] model_q[$];
  int exp_frames, exp_ferr, exp_perr, exp_ovf;

  always #5 clk = ~clk;

  daq_serial_frame_receiver #(
    .ADC_WIDTH  (ADC_WIDTH),
    .CH_BITS    (CH_BITS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .serial_clk       (serial_clk),
    .serial_data      (serial_data),
    .serial_valid     (serial_valid),
    .clear_counts     (clear_counts),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_channel        (m_channel),
    .m_data           (m_data),
    .fifo_level       (fifo_level),
    .frame_count      (frame_count),
    .frame_err_count  (frame_err_count),
    .parity_err_count (parity_err_count),
    .overflow_count   (overflow_count)
  );

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] make_frame(input logic [2:0] ch, input logic [11:0] d,
                                             input logic flip);
    return {ch, d, (^{ch, d}) ^ flip};
  endfunction

  // Drive nbits (MSB first) with 4-cycle serial_clk phases; returns on the
  // negedge where serial_valid has just been dropped.
  task automatic send_frame(input logic [31:0] bits, input int nbits);
    serial_valid = 1'b1;
    wait_neg(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      serial_data = bits[i];
      serial_clk  = 1'b0;
      wait_neg(4);
      serial_clk  = 1'b1;
      wait_neg(4);
    end
    serial_clk = 1'b0;
    wait_neg(4);
    serial_valid = 1'b0;
  endtask

  // Frame fate from the acceptance rules, assuming no pops while frames arrive.
  task automatic model_frame(input logic [15:0] f, input int nbits);
    if (nbits != 16) exp_ferr++;
    else if (PAR_EN && (^f)) exp_perr++;
    else if (model_q.size() >= FIFO_DEPTH) exp_ovf++;
    else begin
      model_q.push_back(f[15:1]);
      exp_frames++;
    end
  endtask

  task automatic send_and_model(input logic [15:0] f, input int nbits, input logic extra);
    logic [31:0] bits;
    if (nbits == 15) bits = {17'd0, f[15:1]};
    else if (nbits == 17) bits = {15'd0, f, extra};
    else bits = {16'd0, f};
    send_frame(bits, nbits);
    model_frame(f, nbits);
    wait_neg(8);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    serial_valid = 1'b0;
    serial_clk   = 1'b0;
    serial_data  = 1'b0;
    m_ready      = 1'b0;
    clear_counts = 1'b0;
    wait_neg(3);
    rst_n = 1'b1;
    wait_neg(3);
    model_q.delete();
    exp_frames = 0; exp_ferr = 0; exp_perr = 0; exp_ovf = 0;
  endtask

  // Pops everything with random back-pressure, checking order and stall stability.
  task automatic drain_and_check(input string tag);
    int          cycles;
    logic        stalled;
    logic [14:0] held;
    cycles  = 0;
    stalled = 1'b0;
    held    = '0;
    m_ready = 1'b0;
    wait_neg(1);
    while (model_q.size() != 0 && cycles < 400) begin
      n_vec++;
      if (m_valid !== 1'b1) begin
        $display("FAIL %s_valid: got %b expected 1", tag, m_valid); n_err++;
      end
      n_vec++;
      if ({m_channel, m_data} !== model_q[0]) begin
        $display("FAIL %s_head: got %h expected %h", tag, {m_channel, m_data}, model_q[0]); n_err++;
      end
      n_vec++;
      if (fifo_level !== LVL_W'(model_q.size())) begin
        $display("FAIL %s_level: got %0d expected %0d", tag, fifo_level, model_q.size()); n_err++;
      end
      if (stalled) begin
        n_vec++;
        if ({m_channel, m_data} !== held) begin
          $display("FAIL %s_stall_hold: got %h expected %h", tag, {m_channel, m_data}, held); n_err++;
        end
      end
      m_ready = 1'($urandom_range(0, 1));
      stalled = !m_ready;
      held    = {m_channel, m_data};
      if (m_ready) void'(model_q.pop_front());
      wait_neg(1);
      cycles++;
    end
    m_ready = 1'b0;
    n_vec++;
    if (model_q.size() != 0) begin
      $display("FAIL %s_drain_timeout: got %0d left expected 0", tag, model_q.size()); n_err++;
    end
    n_vec++;
    if (m_valid !== 1'b0) begin
      $display("FAIL %s_empty_after_drain: got %b expected 0", tag, m_valid); n_err++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (m_valid !== 1'b0) begin $display("FAIL rst_m_valid: got %b expected 0", m_valid); n_err++; end
    n_vec++; if (m_channel !== '0) begin $display("FAIL rst_m_channel: got %0d expected 0", m_channel); n_err++; end
    n_vec++; if (m_data !== '0) begin $display("FAIL rst_m_data: got %h expected 0", m_data); n_err++; end
    n_vec++; if (fifo_level !== '0) begin $display("FAIL rst_level: got %0d expected 0", fifo_level); n_err++; end
    n_vec++; if (frame_count !== '0) begin $display("FAIL rst_frame_count: got %0d expected 0", frame_count); n_err++; end
    n_vec++; if (frame_err_count !== '0) begin $display("FAIL rst_frame_err: got %0d expected 0", frame_err_count); n_err++; end
    n_vec++; if (parity_err_count !== '0) begin $display("FAIL rst_parity_err: got %0d expected 0", parity_err_count); n_err++; end
    n_vec++; if (overflow_count !== '0) begin $display("FAIL rst_overflow: got %0d expected 0", overflow_count); n_err++; end
  endtask

  task automatic test_single_frame();
    logic [15:0] f;
    do_reset();
    f = make_frame(3'd5, 12'hA5C, 1'b0);
    send_frame({16'd0, f}, 16);
    model_frame(f, 16);
    wait_neg(4);
    n_vec++; if (m_valid !== 1'b0) begin $display("FAIL latency_early: got %b expected 0", m_valid); n_err++; end
    wait_neg(1);
    n_vec++; if (m_valid !== 1'b1) begin $display("FAIL latency_rise: got %b expected 1", m_valid); n_err++; end
    n_vec++; if (m_channel !== 3'd5) begin $display("FAIL single_channel: got %0d expected 5", m_channel); n_err++; end
    n_vec++; if (m_data !== 12'hA5C) begin $display("FAIL single_data: got %h expected a5c", m_data); n_err++; end
    n_vec++; if (frame_count !== 16'd1) begin $display("FAIL single_frame_count: got %0d expected 1", frame_count); n_err++; end
    n_vec++; if (fifo_level !== LVL_W'(1)) begin $display("FAIL single_level: got %0d expected 1", fifo_level); n_err++; end
    wait_neg(4);
    drain_and_check("single");
  endtask

  task automatic test_length_errors();
    logic [15:0] f;
    do_reset();
    f = make_frame(3'd2, 12'h3C1, 1'b0);
    send_and_model(f, 15, 1'b0);
    send_and_model(f, 17, 1'b1);
    n_vec++; if (frame_err_count !== 16'd2) begin $display("FAIL len_frame_err: got %0d expected 2", frame_err_count); n_err++; end
    n_vec++; if (m_valid !== 1'b0) begin $display("FAIL len_m_valid: got %b expected 0", m_valid); n_err++; end
    n_vec++; if (frame_count !== 16'd0) begin $display("FAIL len_frame_count: got %0d expected 0", frame_count); n_err++; end
    // serial_clk activity outside a frame must not disturb the next frame.
    for (int i = 0; i < 5; i++) begin
      serial_clk = 1'b1; wait_neg(4);
      serial_clk = 1'b0; wait_neg(4);
    end
    f = make_frame(3'd6, 12'h0F3, 1'b0);
    send_and_model(f, 16, 1'b0);
    n_vec++; if (frame_count !== 16'd1) begin $display("FAIL idle_sclk_frame_count: got %0d expected 1", frame_count); n_err++; end
    n_vec++; if (frame_err_count !== 16'd2) begin $display("FAIL idle_sclk_frame_err: got %0d expected 2", frame_err_count); n_err++; end
    drain_and_check("idle_sclk");
  endtask

  task automatic test_parity();
    logic [15:0] f;
    do_reset();
    f = make_frame(3'd5, 12'hA5C, 1'b1);
    send_and_model(f, 16, 1'b0);
    if (PAR_EN) begin
      n_vec++; if (parity_err_count !== 16'd1) begin $display("FAIL par_err_count: got %0d expected 1", parity_err_count); n_err++; end
      n_vec++; if (frame_count !== 16'd0) begin $display("FAIL par_frame_count: got %0d expected 0", frame_count); n_err++; end
      n_vec++; if (m_valid !== 1'b0) begin $display("FAIL par_m_valid: got %b expected 0", m_valid); n_err++; end
    end else begin
      n_vec++; if (parity_err_count !== 16'd0) begin $display("FAIL par_err_count: got %0d expected 0", parity_err_count); n_err++; end
      n_vec++; if (frame_count !== 16'd1) begin $display("FAIL par_frame_count: got %0d expected 1", frame_count); n_err++; end
      n_vec++; if (m_data !== 12'hA5C) begin $display("FAIL par_data: got %h expected a5c", m_data); n_err++; end
    end
    drain_and_check("parity");
  endtask

  task automatic test_random_frames();
    logic [15:0] f;
    int          sel;
    int          nbits;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      sel   = $urandom_range(0, 7);
      nbits = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
      f = make_frame(3'($urandom), 12'($urandom), 1'($urandom_range(0, 5) == 0));
      send_and_model(f, nbits, 1'($urandom));
    end
    n_vec++; if (frame_count !== 16'(exp_frames)) begin $display("FAIL rand_frame_count: got %0d expected %0d", frame_count, exp_frames); n_err++; end
    n_vec++; if (frame_err_count !== 16'(exp_ferr)) begin $display("FAIL rand_frame_err: got %0d expected %0d", frame_err_count, exp_ferr); n_err++; end
    n_vec++; if (parity_err_count !== 16'(exp_perr)) begin $display("FAIL rand_parity_err: got %0d expected %0d", parity_err_count, exp_perr); n_err++; end
    n_vec++; if (overflow_count !== 16'(exp_ovf)) begin $display("FAIL rand_overflow: got %0d expected %0d", overflow_count, exp_ovf); n_err++; end
    drain_and_check("rand");
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 18; k++) begin
      send_and_model(make_frame(3'($urandom), 12'($urandom), 1'b0), 16, 1'b0);
    end
    n_vec++; if (fifo_level !== LVL_W'(16)) begin $display("FAIL ovf_level: got %0d expected 16", fifo_level); n_err++; end
    n_vec++; if (overflow_count !== 16'd2) begin $display("FAIL ovf_count: got %0d expected 2", overflow_count); n_err++; end
    n_vec++; if (frame_count !== 16'd16) begin $display("FAIL ovf_frame_count: got %0d expected 16", frame_count); n_err++; end
    drain_and_check("ovf");
  endtask

  task automatic test_reset_midframe();
    logic [15:0] f;
    do_reset();
    send_and_model(make_frame(3'd1, 12'h111, 1'b0), 16, 1'b0);
    send_and_model(make_frame(3'd2, 12'h222, 1'b0), 15, 1'b0);
    // Start a frame and abort it with reset after 8 bits.
    f = make_frame(3'd7, 12'hFFF, 1'b0);
    serial_valid = 1'b1;
    wait_neg(4);
    for (int i = 15; i >= 8; i--) begin
      serial_data = f[i]; serial_clk = 1'b0; wait_neg(4);
      serial_clk = 1'b1; wait_neg(4);
    end
    do_reset();
    n_vec++; if (fifo_level !== '0) begin $display("FAIL midrst_level: got %0d expected 0", fifo_level); n_err++; end
    n_vec++; if (frame_err_count !== '0) begin $display("FAIL midrst_frame_err: got %0d expected 0", frame_err_count); n_err++; end
    f = make_frame(3'($urandom), 12'($urandom), 1'b0);
    send_and_model(f, 16, 1'b0);
    n_vec++; if (frame_count !== 16'd1) begin $display("FAIL midrst_frame_count: got %0d expected 1", frame_count); n_err++; end
    n_vec++; if ((frame_err_count | parity_err_count | overflow_count) !== '0) begin
      $display("FAIL midrst_err_counts: got %0d/%0d/%0d expected 0/0/0", frame_err_count, parity_err_count, overflow_count); n_err++;
    end
    n_vec++; if (fifo_level !== LVL_W'(1)) begin $display("FAIL midrst_new_level: got %0d expected 1", fifo_level); n_err++; end
    drain_and_check("midrst");
  endtask

  task automatic test_clear_collision();
    logic [15:0] f;
    do_reset();
    send_and_model(make_frame(3'd3, 12'h321, 1'b0), 16, 1'b0);
    send_and_model(make_frame(3'd4, 12'h654, 1'b0), 16, 1'b0);
    n_vec++; if (frame_count !== 16'd2) begin $display("FAIL clr_pre_count: got %0d expected 2", frame_count); n_err++; end
    f = make_frame(3'd0, 12'h987, 1'b0);
    send_frame({16'd0, f}, 16);
    model_frame(f, 16);
    wait_neg(4);
    clear_counts = 1'b1;
    wait_neg(1);
    clear_counts = 1'b0;
    exp_frames = 0;
    n_vec++; if (frame_count !== 16'd0) begin $display("FAIL clr_frame_count: got %0d expected 0", frame_count); n_err++; end
    n_vec++; if (fifo_level !== LVL_W'(3)) begin $display("FAIL clr_level: got %0d expected 3", fifo_level); n_err++; end
    wait_neg(4);
    send_and_model(make_frame(3'd2, 12'h0AB, 1'b0), 16, 1'b0);
    n_vec++; if (frame_count !== 16'd1) begin $display("FAIL clr_resume_count: got %0d expected 1", frame_count); n_err++; end
    drain_and_check("clr");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_length_errors();
    test_parity();
    test_random_frames();
    test_overflow();
    test_reset_midframe();
    test_clear_collision();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/daq_serial_frame_receiver.md
# daq_serial_frame_receiver

Receive-side deserializer for the DAQ controller's serial sample output. It consumes `serial_clk`, `serial_data` and `serial_valid` from `high_speed_daq_controller`, reassembles each frame into a channel-tagged sample, and buffers the samples in a FIFO. Samples leave through a valid/ready stream to the host/DMA side. Malformed frames are dropped and counted in saturating error counters.

## Interface
Parameters:
- `ADC_WIDTH`, 12, sample data width.
- `CH_BITS`, 3, channel-ID width (8 channels).
- `FIFO_DEPTH`, 16, sample FIFO entries; must be a power of two, ≥ 2.
- `CNT_WIDTH`, 16, width of each statistics counter.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `serial_clk`  in  1  serial bit clock from the controller.
- `serial_data`  in  1  serial data, MSB first.
- `serial_valid`  in  1  frame envelope, high for the whole frame.
- `clear_counts`  in  1  one-cycle pulse that zeroes all counters.
- `m_valid`  out  1  output sample available.
- `m_ready`  in  1  consumer accepts the sample.
- `m_channel`  out  `CH_BITS`  channel ID of the head sample.
- `m_data`  out  `ADC_WIDTH`  data of the head sample.
- `fifo_level`  out  `$clog2(FIFO_DEPTH)+1`  current FIFO occupancy.
- `frame_count`  out  `CNT_WIDTH`  good frames pushed into the FIFO.
- `frame_err_count`  out  `CNT_WIDTH`  frames dropped for wrong length.
- `parity_err_count`  out  `CNT_WIDTH`  frames dropped for bad parity.
- `overflow_count`  out  `CNT_WIDTH`  good frames dropped because the FIFO was full.

## Operation
- Frame format: FRAME_BITS = CH_BITS + ADC_WIDTH + 1 = 16 bits, MSB first: `{channel[2:0], data[11:0], parity}`. Parity is even over the upper 15 bits.
- `serial_clk`, `serial_data` and `serial_valid` each pass through a 2-flop synchronizer. Rising and falling edges are detected on the synchronized copies.
- Frame FSM states: IDLE, SHIFT, CHECK.
  - IDLE -> SHIFT on a sync `serial_valid` rising edge. The bit counter clears to 0.
  - In SHIFT, each sync `serial_clk` rising edge shifts in sync `serial_data`. The bit counter saturates at 31.
  - SHIFT -> CHECK on a sync `serial_valid` falling edge.
  - CHECK lasts one cycle, then returns to IDLE.
- CHECK decision, in priority order:
  1. Bit count ≠ 16: drop the frame, increment `frame_err_count`.
  2. Parity error (only when checking is compiled in): drop, increment `parity_err_count`.
  3. FIFO full and no pop in the same cycle: drop, increment `overflow_count`.
  4. Otherwise: push `{channel, data}` and increment `frame_count`.
- Counters saturate at all-ones. `clear_counts` zeroes them; if `clear_counts` and an increment fall in the same cycle, the clear wins.
- `serial_clk` edges while in IDLE are ignored.
- Output stream: `m_valid` is high while the FIFO is non-empty. `m_channel` and `m_data` show the head entry (first-word-fall-through). A pop occurs when `m_valid && m_ready`.
- `m_channel` and `m_data` must remain stable while `m_valid` is high and `m_ready` is low.
- Reset mid-frame: the FSM returns to IDLE, the partial frame is discarded, and the FIFO is emptied. After reset the block waits for a fresh `serial_valid` rising edge.

## Timing
- Reset values: `m_valid` = 0, `m_channel` = 0, `m_data` = 0, `fifo_level` = 0, all counters = 0, FSM = IDLE, synchronizers = 0.
- Input requirement: `serial_clk` high and low phases are each ≥ 3 `clk` periods. Faster input is unsupported.
- Latency: `m_valid` rises on the 4th `clk` rising edge after the first edge that samples `serial_valid` low on an empty FIFO. That is 2 synchronizer cycles + 1 CHECK cycle + 1 push.
- `fifo_level` updates in the same cycle as the push or pop. A simultaneous push and pop leaves the level unchanged.
- Counters update one cycle after CHECK.

## Configuration
- `DAQ_RX_PARITY_CHECK_EN` defined: parity is verified, bad frames are dropped, and `parity_err_count` is active.
- Not defined: the parity bit is shifted in but ignored, no frame is ever dropped for parity, and `parity_err_count` is tied to 0.

## Structure
- Package `daq_rx_pkg` holds:
  - the constants `CH_BITS`, `FRAME_BITS`, `ADC_WIDTH`;
  - the typedef `daq_sample_t` (packed `{channel, data}`);
  - the FSM state enum `rx_state_e`.
- Sub-module `daq_rx_fifo`: synchronous FWFT FIFO of `daq_sample_t` with full, empty and level outputs; the top instantiates it once.

## Test plan
- Single good frame `{ch=5, data=0xA5C, parity=0}` -> `m_valid` rises 4 cycles after the frame ends; `m_channel` = 5, `m_data` = 0xA5C; `frame_count` = 1.
- Frame of 15 bits, then a frame of 17 bits -> nothing pushed; `frame_err_count` = 2; `m_valid` stays 0.
- Frame `{ch=5, data=0xA5C, parity=1}` -> with the macro: dropped, `parity_err_count` = 1. Without the macro: pushed, `frame_count` = 1.
- `m_ready` = 0, send 18 good frames with `FIFO_DEPTH` = 16 -> `fifo_level` = 16, `overflow_count` = 2. Then drain with `m_ready` = 1 -> 16 samples read out in order, head held stable while stalled.
- Assert `rst_n` low after 8 bits of a frame, release, then send one good frame -> only the new sample appears; all counters read 0 except `frame_count` = 1.
- Pulse `clear_counts` in the same cycle as a good-frame increment -> `frame_count` = 0 afterwards; the sample is still pushed.
